ccff_chain_loader: RTL

- Sequences bitstream loading into a tile's configuration chain (ccff_head → ... → ccff_tail), e.g. a connection block's mux SRAM bits followed by its IO config bit.
- Accepts WORD_W-bit bitstream words over a valid/ready stream and serializes them onto ccff_head.
- Drives a clock-gate enable so chain flops shift only when a valid bit is presented.
- Stops after exactly CHAIN_LEN bits; optionally verifies the load by non-destructive recirculation.

---
 rtl/ccff_chain_loader_if.sv | 19 +
 rtl/ccff_chain_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader_if.sv
// ============================================================================
// Module      : ccff_chain_loader_if
// Description : Valid/ready bitstream word stream feeding ccff_chain_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// Module      : ccff_chain_loader
// Description : Serializes bitstream words LSB-first into a configuration
//               chain, gating the chain clock so it only shifts on fresh bits.
//               Optional recirculating CRC verify: CCFF_LOADER_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_chain_loader #(
   parameter int CHAIN_LEN = 5,
   parameter int WORD_W    = 8
) (
   input  logic                prog_clk,
   input  logic                prog_reset,
   input  logic                start,
   ccff_chain_loader_if.slave  cfg,
   output logic                ccff_head,
   input  logic                ccff_tail,
   output logic                chain_clk_en,
   output logic                busy,
   output logic                done,
   output logic                verify_fail
);

   localparam int BCW = $clog2(CHAIN_LEN + 1);
   localparam int WCW = $clog2(WORD_W + 1);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LEN - 1);
   localparam logic [WCW-1:0] LAST_WBIT = WCW'(WORD_W - 1);

`ifdef CCFF_LOADER_VERIFY_EN
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_WORD = 3'd1,
      S_SHIFT     = 3'd2,
      S_DONE      = 3'd3,
      S_VERIFY    = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_WORD = 3'd1,
      S_SHIFT     = 3'd2,
      S_DONE      = 3'd3
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  sreg_q, sreg_d;
   logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]     word_cnt_q, word_cnt_d;

`ifdef CCFF_LOADER_VERIFY_EN
   logic [15:0]        crc_ld_q, crc_ld_d;
   logic [15:0]        crc_rb_q, crc_rb_d;
   logic               verify_fail_q, verify_fail_d;

   // Serial CRC-16-CCITT, MSB-first register, one data bit per call.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   assign verify_fail = verify_fail_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign verify_fail = 1'b0;
`endif

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q       <= S_IDLE;
         sreg_q        <= '0;
         bit_cnt_q     <= '0;
         word_cnt_q    <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
         crc_ld_q      <= '0;
         crc_rb_q      <= '0;
         verify_fail_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         sreg_q        <= sreg_d;
         bit_cnt_q     <= bit_cnt_d;
         word_cnt_q    <= word_cnt_d;
`ifdef CCFF_LOADER_VERIFY_EN
         crc_ld_q      <= crc_ld_d;
         crc_rb_q      <= crc_rb_d;
         verify_fail_q <= verify_fail_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      sreg_d        = sreg_q;
      bit_cnt_d     = bit_cnt_q;
      word_cnt_d    = word_cnt_q;
      cfg.cfg_ready = 1'b0;
      ccff_head     = 1'b0;
      chain_clk_en  = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
      crc_ld_d      = crc_ld_q;
      crc_rb_d      = crc_rb_q;
      verify_fail_d = verify_fail_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_WAIT_WORD;
               bit_cnt_d = '0;
`ifdef CCFF_LOADER_VERIFY_EN
               crc_ld_d      = 16'hFFFF;
               verify_fail_d = 1'b0;
`endif
            end
         end
         S_WAIT_WORD: begin
            cfg.cfg_ready = 1'b1;
            busy          = 1'b1;
            if (cfg.cfg_valid) begin
               sreg_d     = cfg.cfg_data;
               word_cnt_d = '0;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy         = 1'b1;
            chain_clk_en = 1'b1;
            ccff_head    = sreg_q[0];
            sreg_d       = sreg_q >> 1;
            bit_cnt_d    = bit_cnt_q + BCW'(1);
            word_cnt_d   = word_cnt_q + WCW'(1);
`ifdef CCFF_LOADER_VERIFY_EN
            crc_ld_d     = crc_step(crc_ld_q, sreg_q[0]);
`endif
            // The chain-length limit wins over the word boundary.
            if (bit_cnt_q == LAST_BIT) begin
`ifdef CCFF_LOADER_VERIFY_EN
               state_d   = S_VERIFY;
               bit_cnt_d = '0;
               crc_rb_d  = 16'hFFFF;
`else
               state_d   = S_DONE;
`endif
            end else if (word_cnt_q == LAST_WBIT) begin
               state_d = S_WAIT_WORD;
            end
         end
`ifdef CCFF_LOADER_VERIFY_EN
         S_VERIFY: begin
            busy         = 1'b1;
            chain_clk_en = 1'b1;
            ccff_head    = ccff_tail;
            crc_rb_d     = crc_step(crc_rb_q, ccff_tail);
            bit_cnt_d    = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == LAST_BIT) begin
               verify_fail_d = (crc_ld_q != crc_rb_d);
               state_d       = S_DONE;
            end
         end
`endif
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire
